// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the iterative multiplier.
//                - mulState_t : FSM state encoding (IDLE, RUN, DONE)
//                - ALU_MUL / ALU_MLA : ALUControlE encodings, also used by
//                  the controller decode
//                - calcIters : iteration count for a width / retire rate
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulState_t;

    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_MLA = 4'b0101;

    // Number of iterations needed to retire every multiplier bit.
    function automatic int calcIters(input int width, input int bitsPerCycle);
        return width / bitsPerCycle;
    endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_iter_unit_step.sv
`default_nettype none
// ============================================================================
//  Module      : mul_step
//  Description : Combinational partial-product adder for one iteration slice.
//                sum = pp + mcand * mbits, truncated to WIDTH bits.
//  Ports       : pp    in  WIDTH           running partial product
//                mcand in  WIDTH           multiplicand, already shifted
//                mbits in  BITS_PER_CYCLE  multiplier bits for this slice
//                sum   out WIDTH           updated partial product
//  Revision    : 1.0  initial release
// ============================================================================
module mul_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [WIDTH-1:0]          pp,
    input  logic [WIDTH-1:0]          mcand,
    input  logic [BITS_PER_CYCLE-1:0] mbits,
    output logic [WIDTH-1:0]          sum
);

    // Shift-and-add over the slice: a small adder chain instead of a
    // generic multiplier, so the per-cycle path stays short.
    always_comb begin
        sum = pp;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mbits[i]) begin
                sum = sum + (mcand << i);
            end
        end
    end

endmodule : mul_step
`default_nettype wire

// File: rtl/mul_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter_unit
//  Description : Iterative MUL / MLA unit for the execute stage. Retires
//                BITS_PER_CYCLE multiplier bits per cycle with a fixed
//                latency of ITERS+1 cycles from the accepting cycle, and
//                holds the pipeline via stall while it iterates.
//  Ports       : clk, reset (sync, active-high)
//                start    accept a new multiply (MulOpE & CondExE)
//                flush    abort any in-flight operation
//                op       ALUControlE, op[0] selects MLA
//                srca/srcb/acc  multiplicand / multiplier / accumulator
//                setflags S bit
//                stall    stall request to the hazard unit
//                done     one-cycle completion pulse
//                result   low WIDTH bits of srca*srcb (+acc)
//                flags_n / flags_z / flags_we  N/Z flag update
//  Revision    : 1.0  initial release
// ============================================================================
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] acc,
    input  logic             setflags,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flags_n,
    output logic             flags_z,
    output logic             flags_we
);

    localparam int ITERS = calcIters(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(ITERS - 1);

    mulState_t          r_state;
    mulState_t          w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_pp;
    logic               r_setflags;
    logic [WIDTH-1:0]   r_result;
    logic               r_flagN;
    logic               r_flagZ;
    logic [WIDTH-1:0]   w_ppNext;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && start && !flush;

    mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .pp    (r_pp),
        .mcand (r_mcand),
        .mbits (r_mplier[BITS_PER_CYCLE-1:0]),
        .sum   (w_ppNext)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_nextState = IDLE;
                end else if (r_cnt == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // done is gated by flush so an instruction killed in E in its completion
    // cycle never reports a result or writes flags.
    always_comb begin
        stall    = w_accept || (r_state == RUN);
        done     = (r_state == DONE) && !flush;
        flags_we = done && r_setflags;
    end

    assign result  = r_result;
    assign flags_n = r_flagN;
    assign flags_z = r_flagZ;

    // ------------------------------------------------------------- datapath
    // Operands are captured only on the accepting edge; the result and flags
    // are written only by the final RUN iteration, so a flush leaves them
    // untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_pp       <= '0;
            r_setflags <= 1'b0;
            r_result   <= '0;
            r_flagN    <= 1'b0;
            r_flagZ    <= 1'b0;
        end else if (w_accept) begin
            r_mcand    <= srca;
            r_mplier   <= srcb;
            r_pp       <= op[0] ? acc : '0;
            r_setflags <= setflags;
            r_cnt      <= C_CNT_LOAD;
        end else if ((r_state == RUN) && !flush) begin
            r_pp     <= w_ppNext;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_result <= w_ppNext;
                r_flagN  <= w_ppNext[WIDTH-1];
                r_flagZ  <= (w_ppNext == '0);
            end
        end
    end

    // The controller must not issue while stall is high, and decode only
    // raises start for MUL / MLA.
    a_startOnlyInIdle : assert property (@(posedge clk) disable iff (reset)
        (start && !flush) |-> (r_state == IDLE));

    a_legalOp : assert property (@(posedge clk) disable iff (reset)
        w_accept |-> ((op == ALU_MUL) || (op == ALU_MLA)));

endmodule : mul_iter_unit
`default_nettype wire

// File: tb/tb_mul_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_iter_unit
//  Description : Directed self-checking bench for mul_iter_unit. Three
//                instances (2, 1 and 4 bits per cycle) share all inputs
//                except start, so latency can be checked per retire rate.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_iter_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] acc;
    logic        setflags;
    logic        start2, start1, start4;

    logic        stall2, done2, fn2, fz2, fwe2;
    logic        stall1, done1, fn1, fz1, fwe1;
    logic        stall4, done4, fn4, fz4, fwe4;
    logic [31:0] result2, result1, result4;

    int nChecks = 0;
    int nFail   = 0;
    int sel     = 2;

    logic        mStall, mDone, mFn, mFz, mFwe;
    logic [31:0] mResult;

    assign mStall  = (sel == 1) ? stall1  : (sel == 4) ? stall4  : stall2;
    assign mDone   = (sel == 1) ? done1   : (sel == 4) ? done4   : done2;
    assign mFn     = (sel == 1) ? fn1     : (sel == 4) ? fn4     : fn2;
    assign mFz     = (sel == 1) ? fz1     : (sel == 4) ? fz4     : fz2;
    assign mFwe    = (sel == 1) ? fwe1    : (sel == 4) ? fwe4    : fwe2;
    assign mResult = (sel == 1) ? result1 : (sel == 4) ? result4 : result2;

    mul_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
        .clk(clk), .reset(reset), .start(start2), .flush(flush), .op(op),
        .srca(srca), .srcb(srcb), .acc(acc), .setflags(setflags),
        .stall(stall2), .done(done2), .result(result2),
        .flags_n(fn2), .flags_z(fz2), .flags_we(fwe2)
    );

    mul_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .flush(flush), .op(op),
        .srca(srca), .srcb(srcb), .acc(acc), .setflags(setflags),
        .stall(stall1), .done(done1), .result(result1),
        .flags_n(fn1), .flags_z(fz1), .flags_we(fwe1)
    );

    mul_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .flush(flush), .op(op),
        .srca(srca), .srcb(srcb), .acc(acc), .setflags(setflags),
        .stall(stall4), .done(done4), .result(result4),
        .flags_n(fn4), .flags_z(fz4), .flags_we(fwe4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one operation on instance s and check latency, stall span,
    // result and flags at the done cycle, then that done is a single pulse.
    task automatic doOp(input string tag, input int s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic mla, input logic sf,
                        input int expLat, input logic [31:0] expRes,
                        input logic expN, input logic expZ);
        int  lat;
        int  stl;
        logic seen;
        @(negedge clk);
        sel      = s;
        srca     = a;
        srcb     = b;
        acc      = c;
        op       = mla ? 4'b0101 : 4'b0100;
        setflags = sf;
        if (s == 1)      start1 = 1'b1;
        else if (s == 4) start4 = 1'b1;
        else             start2 = 1'b1;
        #1;
        checkVal({tag, "_stallAtStart"}, 32'(mStall), 32'd1);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        srca   = 32'hDEAD_BEEF;
        srcb   = 32'h1234_5678;
        acc    = 32'h5555_AAAA;
        lat    = 1;
        stl    = 1;
        seen   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mDone) begin
                seen = 1'b1;
                break;
            end
            if (mStall) stl++;
            lat++;
            @(posedge clk);
            #1;
        end
        checkVal({tag, "_doneSeen"}, 32'(seen), 32'd1);
        checkVal({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkVal({tag, "_stallCycles"}, 32'(stl), 32'(expLat));
        checkVal({tag, "_stallInDone"}, 32'(mStall), 32'd0);
        checkVal({tag, "_result"}, mResult, expRes);
        checkVal({tag, "_flagN"}, 32'(mFn), 32'(expN));
        checkVal({tag, "_flagZ"}, 32'(mFz), 32'(expZ));
        checkVal({tag, "_flagWe"}, 32'(mFwe), 32'(sf));
        @(posedge clk);
        #1;
        checkVal({tag, "_donePulse"}, 32'(mDone), 32'd0);
        checkVal({tag, "_resultHeld"}, mResult, expRes);
        sel = 2;
    endtask

    initial begin
        int seenDone;
        reset    = 1'b1;
        flush    = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        start4   = 1'b0;
        op       = 4'b0100;
        srca     = '0;
        srcb     = '0;
        acc      = '0;
        setflags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_stall",  32'(stall2), 32'd0);
        checkVal("rst_done",   32'(done2),  32'd0);
        checkVal("rst_result", result2,     32'd0);
        checkVal("rst_flagN",  32'(fn2),    32'd0);
        checkVal("rst_flagZ",  32'(fz2),    32'd0);
        checkVal("rst_flagWe", 32'(fwe2),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic MUL, MLA wrap-around, N flag, larger operands with wrap to 0.
        doOp("mul7x6",  2, 32'd7,          32'd6, 32'd0, 1'b0, 1'b1, 17, 32'd42,         1'b0, 1'b0);
        doOp("mlaWrap", 2, 32'hFFFF_FFFF,  32'd2, 32'd3, 1'b1, 1'b0, 17, 32'h0000_0001,  1'b0, 1'b0);
        doOp("mlaBig",  2, 32'h0001_0001,  32'h0001_0001, 32'hFFFD_FFFF, 1'b1, 1'b1, 17, 32'h0, 1'b0, 1'b1);
        doOp("mulNeg",  2, 32'h8000_0000,  32'd1, 32'd0, 1'b0, 1'b1, 17, 32'h8000_0000,  1'b1, 1'b0);

        // Flush at RUN iteration 5: no done, stall drops, result unchanged.
        @(negedge clk);
        srca = 32'd9; srcb = 32'd9; op = 4'b0100; setflags = 1'b1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkVal("flush_stallBefore", 32'(stall2), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkVal("flush_stallAfter", 32'(stall2), 32'd0);
        checkVal("flush_result", result2, 32'h8000_0000);
        seenDone = 0;
        repeat (20) begin
            if (done2) seenDone++;
            @(posedge clk);
            #1;
        end
        checkVal("flush_noDone", 32'(seenDone), 32'd0);
        checkVal("flush_resultLater", result2, 32'h8000_0000);
        doOp("afterFlush", 2, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 17, 32'd81, 1'b0, 1'b0);

        // flush and start together in IDLE: nothing accepted.
        @(negedge clk);
        srca = 32'd4; srcb = 32'd4; start2 = 1'b1; flush = 1'b1;
        #1;
        checkVal("flushStart_stall", 32'(stall2), 32'd0);
        @(posedge clk);
        #1;
        start2 = 1'b0;
        flush  = 1'b0;
        checkVal("flushStart_stallNext", 32'(stall2), 32'd0);

        // Zero operands.
        doOp("mulZeroB", 2, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b1, 17, 32'd0, 1'b0, 1'b1);
        doOp("mlaZeroA", 2, 32'd0, 32'd5, 32'h8000_0000, 1'b1, 1'b1, 17, 32'h8000_0000, 1'b1, 1'b0);
        doOp("mul81",    2, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 17, 32'd81, 1'b0, 1'b0);

        // Reset mid-RUN returns all outputs to reset values.
        @(negedge clk);
        srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF; op = 4'b0100; setflags = 1'b1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkVal("midRst_stall",  32'(stall2), 32'd0);
        checkVal("midRst_done",   32'(done2),  32'd0);
        checkVal("midRst_result", result2,     32'd0);
        checkVal("midRst_flagN",  32'(fn2),    32'd0);
        checkVal("midRst_flagZ",  32'(fz2),    32'd0);
        checkVal("midRst_flagWe", 32'(fwe2),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        doOp("mul3x5", 2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 17, 32'd15, 1'b0, 1'b0);

        // Other retire rates: same results, latency ITERS+1.
        doOp("bpc1_mul", 1, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 33, 32'd42, 1'b0, 1'b0);
        doOp("bpc1_mla", 1, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 1'b0, 33, 32'h1, 1'b0, 1'b0);
        doOp("bpc4_mul", 4, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 9, 32'd42, 1'b0, 1'b0);
        doOp("bpc4_mla", 4, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 1'b0, 9, 32'h1, 1'b0, 1'b0);
        doOp("bpc4_neg", 4, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 9, 32'h8000_0000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule : tb_mul_iter_unit
`default_nettype wire

// File: doc/mul_iter_unit.md
Name: mul_iter_unit

Overview:
- Iterative multiplier in the execute stage, directly downstream of the pipeline controller.
- Consumes MulOpE, ALUControlE (4'b0100 MUL, 4'b0101 MLA) and the E-stage operands; produces a 32-bit result plus N/Z flags.
- Holds the pipeline with a stall request while it iterates.
- Replaces the single-cycle multiply path so that the ALU critical path no longer contains a 32x32 array.

Parameters:
- WIDTH, 32, operand and result width.
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration; legal values 1, 2, 4; WIDTH % BITS_PER_CYCLE == 0.
- ITERS, WIDTH/BITS_PER_CYCLE, derived iteration count; not for override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  MulOpE & CondExE: accept a new multiply this cycle.
- flush  in  1  FlushE-equivalent abort; kills any in-flight operation.
- op  in  4  ALUControlE; bit 0 = 1 selects MLA (accumulate).
- srca  in  WIDTH  multiplicand (Rm).
- srcb  in  WIDTH  multiplier (Rs).
- acc  in  WIDTH  accumulator (Rn); used only when op[0] = 1.
- setflags  in  1  S bit; enables flag update on completion.
- stall  out  1  stall request to the hazard unit (freeze F/D/E).
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  WIDTH  low WIDTH bits of srca*srcb (+acc).
- flags_n  out  1  result[WIDTH-1], valid with done.
- flags_z  out  1  result == 0, valid with done.
- flags_we  out  1  = done & setflags; C and V are never written.

Behaviour:
- Reset: state = IDLE; stall = 0, done = 0, flags_we = 0, result = 0, flags_n = 0, flags_z = 0; counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start = 1 and flush = 0: latch srca, srcb, op[0], setflags.
  - Load the partial product with acc if op[0] = 1, else 0.
  - Set counter = ITERS - 1 and go to RUN.
  - Operand latches are written only on this accepting edge.
- RUN:
  - Each cycle add (mcand << shift) * multiplier[BITS_PER_CYCLE-1:0] into the partial product.
  - Shift the multiplier right by BITS_PER_CYCLE and the multiplicand left by BITS_PER_CYCLE.
  - All arithmetic is truncated to WIDTH bits; overflow is discarded.
  - Counter decrements; at counter == 0, the last iteration completes and the FSM goes to DONE.
- DONE: done = 1 for exactly one cycle; result and flags held; next state IDLE.
- result is registered and holds its last value in IDLE until the next completion.
- Latency: start sampled at edge T, done high during cycle T+ITERS+1 (ITERS = 16 gives done 17 cycles after start).
- stall:
  - Combinational: (state == IDLE & start & ~flush) | (state == RUN).
  - Low in DONE, so the stalled MUL/MLA advances to M in the done cycle.
- Early termination: none. Latency is fixed regardless of operand values, and the hazard unit relies on this.
- Signedness: unsigned datapath. The low WIDTH bits are identical for signed and unsigned operands.
- Boundary conditions:
  - start while in RUN or DONE: ignored. The controller cannot issue it while stall is high; an assertion flags a violation.
  - flush in any state: next state IDLE, no done pulse, result unchanged, stall drops next cycle.
  - flush and start in the same IDLE cycle: flush wins; nothing accepted.
  - reset mid-RUN: IDLE on the next edge; outputs return to their reset values.
  - srcb = 0 or srca = 0: result = acc (MLA) or 0 (MUL); flags_z reflects this.
  - op values other than 0100/0101 with start = 1: treated as MUL/MLA by op[0]. Decode guarantees that start is only asserted with legal ops.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, RUN, DONE};
  - ALU control constants ALU_MUL = 4'b0100 and ALU_MLA = 4'b0101, also used by the controller decode;
  - localparam function for ITERS.
- One natural sub-module: mul_step. It is a combinational partial-product adder taking (pp, mcand, mbits) and returning pp + mcand*mbits truncated to WIDTH. It is instantiated once per iteration slice.
- FSM, counter and operand registers stay in mul_iter_unit.

Test Plan:
- MUL, srca = 7, srcb = 6, setflags = 1 -> stall high for 17 cycles; done in cycle 17 after start; result = 42; flags_n = 0; flags_z = 0; flags_we = 1.
- MLA, srca = 0xFFFFFFFF, srcb = 2, acc = 3, setflags = 0 -> result = 0x00000001 (wrap-around); flags_we = 0.
- MUL, srca = 0x80000000, srcb = 1, setflags = 1 -> result = 0x80000000; flags_n = 1; flags_z = 0. Repeat with srcb = 0 -> result = 0, flags_z = 1.
- start, then flush at RUN iteration 5 -> no done pulse; stall low on the following cycle; result keeps its previous value; a new start 2 cycles later completes normally.
- reset asserted mid-RUN, then a new MUL 3 x 5 -> all outputs at reset values the next cycle; second op yields 15 with nominal latency.
- Back-to-back: start held high through RUN with a different srca -> only the first op executes; its result is unaffected; assertion on the illegal start fires. Repeat with BITS_PER_CYCLE = 1 and 4 -> latency 33 and 9 cycles, same results.
